serial_addh_adder: RTL and testbench
====================================

Name: serial_addh_adder

Overview:
- Bit-serial WIDTH-bit adder for area-critical datapaths in the 9T standard-cell flow.
- Each bit is processed by one full-adder slice, built from two half-adder cells plus an OR, with a registered carry.
- Operands arrive through a valid/ready handshake, are shifted LSB-first, and the result is presented through a second valid/ready handshake.
- Sits downstream of operand registers and upstream of result consumers. It trades WIDTH cycles of latency for a single adder slice.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64; elaboration error outside this range.
- CNT_W, $clog2(WIDTH)+1, width of the bit counter; localparam, not overridable.

Ports:
- CLK  input  1  clock, rising edge.
- RN  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operands A/B valid.
- IN_READY  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- OUT_VALID  output  1  SUM/CO valid.
- OUT_READY  input  1  consumer accepts the result.
- SUM  output  WIDTH  (A+B) mod 2^WIDTH.
- CO  output  1  carry out of the MSB.

Behaviour:
- One clock: CLK. Reset RN is asynchronous and active-low.
- Reset values (RN=0): state=IDLE, IN_READY=1, OUT_VALID=0, SUM=0, CO=0, carry flop=0, counter=0, operand shift registers=0.
- Reset takes effect immediately on RN falling. Any operation in flight is discarded with no partial output.
- FSM states and transitions:
  - IDLE -> SHIFT on IN_VALID&&IN_READY.
  - SHIFT -> DONE after WIDTH bit-cycles.
  - DONE -> IDLE on OUT_VALID&&OUT_READY.
- IN_READY=1 only in IDLE. IN_VALID in any other state is ignored, and A/B are not sampled.
- On accept: A and B are loaded into shift registers, carry flop cleared, counter cleared.
- In SHIFT, each cycle:
  - Slice computes s = a0^b0^c and c' = a0&b0 | (a0^b0)&c.
  - s is shifted into the MSB of the SUM register (right shift), and c' is registered.
  - Operand registers shift right by one; counter increments.
  - Exit when counter reaches WIDTH-1 on that cycle's edge.
- DONE:
  - OUT_VALID=1; SUM holds the full result; CO=final carry.
  - SUM and CO are stable while OUT_VALID=1 and OUT_READY=0; stall is unbounded.
- Latency: accept edge -> OUT_VALID high after exactly WIDTH+1 rising edges.
- Throughput: one operation per WIDTH+2 cycles minimum. No accept in the same cycle as the output handshake.
- SUM/CO after the output handshake keep their last value until the next DONE. They are only defined while OUT_VALID=1.
- WIDTH=1: a single SHIFT cycle. Counter compare still works with CNT_W=1.
- Wrap: the counter never exceeds WIDTH-1 and is cleared on accept.

Optional Feature:
- Macro: SERIAL_ADDH_SUB_EN.
- With the macro defined:
  - Extra input port SUB (1 bit), sampled with A/B on accept.
  - SUB=1 computes A-B: B is inverted at load and the carry flop is set to 1 at accept.
  - CO=1 means no borrow (A>=B, unsigned).
- Without the macro: no SUB port; addition only; carry cleared at accept.

Decomposition:
- Package serial_addh_pkg:
  - state enum typedef (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10).
  - localparam WIDTH_MAX=64.
  - function for CNT_W.
- Sub-module serial_addh_fa_slice: combinational full adder of two half-adder instances plus an OR. Ports a, b, ci, s, co.
  - First half adder: s1=a^b, c1=a&b.
  - Second half adder: s=s1^ci, c2=s1&ci.
  - co=c1|c2.
- Top module holds the FSM, counter, shift registers and carry flop.

Test Plan:
- Reset mid-SHIFT: accept A=8'h55, B=8'h0F, pull RN low on cycle 3. Required: OUT_VALID=0, IN_READY=1 immediately; SUM=0, CO=0. Next op A=1, B=1 gives SUM=2.
- Basic add, WIDTH=8: A=8'h3C, B=8'h45, OUT_READY=1. Required: SUM=8'h81, CO=0, OUT_VALID high exactly 9 edges after accept.
- Overflow: A=8'hFF, B=8'h01. Required: SUM=8'h00, CO=1; A=8'hFF, B=8'hFF gives SUM=8'hFE, CO=1.
- Backpressure: OUT_READY=0 for 20 cycles after DONE. Required: OUT_VALID and SUM stable, IN_READY=0, and IN_VALID pulses with new operands ignored. Release gives one handshake, then IDLE.
- Edge width: WIDTH=1, A=1, B=1. Required: SUM=0, CO=1 after 2 edges. Random 1000-op regression at WIDTH=13 against a reference model, with random valid/ready gaps.
- With SERIAL_ADDH_SUB_EN, WIDTH=8:
  - SUB=1, A=8'h10, B=8'h03 gives SUM=8'h0D, CO=1.
  - SUB=1, A=8'h03, B=8'h10 gives SUM=8'hF3, CO=0.

Source files
------------

// File: rtl/serial_addh_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_addh_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int WIDTH_MAX = 64;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_addh_fa_slice.sv
// Single-bit full adder built from two half-adder cells and an OR.
module serial_addh_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_addh_fa_slice (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    serial_addh_ha u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
    serial_addh_ha u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

    assign co = c1 | c2;
endmodule

// File: rtl/serial_addh_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with valid/ready on both sides.
// Define SERIAL_ADDH_SUB_EN to add the SUB input (A-B via inverted B and carry-in of 1).
//
// state | meaning
// IDLE  | waiting for operands, IN_READY high
// SHIFT | one slice evaluation per cycle, WIDTH cycles
// DONE  | result presented, held until OUT_READY
module serial_addh_adder
    import serial_addh_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CO
`ifdef SERIAL_ADDH_SUB_EN
    ,
    input  logic             SUB
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_chk
        $error("serial_addh_adder: WIDTH must be in 1..64");
    end

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   sum_q;
    logic               co_q;
    logic               carry_q;
    logic               s_bit;
    logic               c_bit;
    logic               accept;
    logic               last_bit;

    serial_addh_fa_slice u_slice (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry_q),
        .s  (s_bit),
        .co (c_bit)
    );

    assign accept   = IN_VALID && (state_q == IDLE);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    assign acc_next = WIDTH'({s_bit, acc} >> 1);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    if (OUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (state_q == IDLE);
        OUT_VALID = (state_q == DONE);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            carry_q <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            a_sh <= A;
`ifdef SERIAL_ADDH_SUB_EN
            b_sh    <= SUB ? ~B : B;
            carry_q <= SUB;
`else
            b_sh    <= B;
            carry_q <= 1'b0;
`endif
        end else if (state_q == SHIFT) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            acc     <= acc_next;
            carry_q <= c_bit;
            // Result registers only update on the final bit so SUM/CO hold between ops.
            if (last_bit) begin
                sum_q <= acc_next;
                co_q  <= c_bit;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign SUM = sum_q;
    assign CO  = co_q;

endmodule

// File: tb/tb_serial_addh_adder.sv
// Self-checking bench for serial_addh_adder at WIDTH 8, 1 and 13.
module tb_serial_addh_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn8;
    logic rn_x;

    logic       iv8, ir8, ov8, ordy8, co8;
    logic [7:0] a8, b8, s8;
    logic       iv1, ir1, ov1, ordy1, co1;
    logic [0:0] a1, b1, s1;
    logic        iv13, ir13, ov13, ordy13, co13;
    logic [12:0] a13, b13, s13;
`ifdef SERIAL_ADDH_SUB_EN
    logic sub8, sub1, sub13;
`endif

    serial_addh_adder #(.WIDTH(8)) u_w8 (
        .CLK(clk), .RN(rn8), .IN_VALID(iv8), .IN_READY(ir8), .A(a8), .B(b8),
        .OUT_VALID(ov8), .OUT_READY(ordy8), .SUM(s8), .CO(co8)
`ifdef SERIAL_ADDH_SUB_EN
        , .SUB(sub8)
`endif
    );

    serial_addh_adder #(.WIDTH(1)) u_w1 (
        .CLK(clk), .RN(rn_x), .IN_VALID(iv1), .IN_READY(ir1), .A(a1), .B(b1),
        .OUT_VALID(ov1), .OUT_READY(ordy1), .SUM(s1), .CO(co1)
`ifdef SERIAL_ADDH_SUB_EN
        , .SUB(sub1)
`endif
    );

    serial_addh_adder #(.WIDTH(13)) u_w13 (
        .CLK(clk), .RN(rn_x), .IN_VALID(iv13), .IN_READY(ir13), .A(a13), .B(b13),
        .OUT_VALID(ov13), .OUT_READY(ordy13), .SUM(s13), .CO(co13)
`ifdef SERIAL_ADDH_SUB_EN
        , .SUB(sub13)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       co;
        string      name;
    } vec_t;

    typedef struct packed {
        logic [7:0] sum;
        logic       co;
    } res8_t;

    vec_t        vecs[$];
    res8_t       sb8[$];
    logic [13:0] sb13[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int n;
        n = 0;
        while (!ir8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", ir8, 1);
        iv8 = 1'b1;
        a8  = a;
        b8  = b;
`ifdef SERIAL_ADDH_SUB_EN
        sub8 = sub;
`endif
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    // Edge count includes the accept edge.
    task automatic wait_out8(output int edges);
        edges = 1;
        while (!ov8 && edges < 64) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("out_valid_timeout", ov8, 1);
    endtask

    task automatic pop8(input string name);
        res8_t e;
        chk({name, "_sb_size"}, sb8.size(), 1);
        if (sb8.size() != 0) begin
            e = sb8.pop_front();
            chk({name, "_sum"}, s8, e.sum);
            chk({name, "_co"}, co8, e.co);
        end
    endtask

    task automatic do_op8(input vec_t v);
        int edges;
        ordy8 = 1'b1;
        sb8.push_back('{sum: v.sum, co: v.co});
        start8(v.a, v.b, v.sub);
        wait_out8(edges);
        chk({v.name, "_latency"}, edges, 9);
        pop8(v.name);
        @(negedge clk);
        chk({v.name, "_post_ov"}, ov8, 0);
        chk({v.name, "_post_ir"}, ir8, 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        rn8 = 1'b0; rn_x = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; ordy8 = 0;
        iv1 = 0; a1 = 0; b1 = 0; ordy1 = 0;
        iv13 = 0; a13 = 0; b13 = 0; ordy13 = 0;
`ifdef SERIAL_ADDH_SUB_EN
        sub8 = 0; sub1 = 0; sub13 = 0;
`endif
        #1;
        chk("rst_in_ready", ir8, 1);
        chk("rst_out_valid", ov8, 0);
        chk("rst_sum", s8, 0);
        chk("rst_co", co8, 0);
        @(negedge clk);
        @(negedge clk);
        rn8 = 1'b1; rn_x = 1'b1;
        @(negedge clk);

        // Reset in the middle of a shift.
        ordy8 = 1'b1;
        start8(8'h55, 8'h0F, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rn8 = 1'b0;
        #1;
        chk("midrst_out_valid", ov8, 0);
        chk("midrst_in_ready", ir8, 1);
        chk("midrst_sum", s8, 0);
        chk("midrst_co", co8, 0);
        @(negedge clk);
        rn8 = 1'b1;
        @(negedge clk);
        do_op8('{a: 8'h01, b: 8'h01, sub: 1'b0, sum: 8'h02, co: 1'b0, name: "after_rst"});

        vecs.push_back('{a: 8'h3C, b: 8'h45, sub: 1'b0, sum: 8'h81, co: 1'b0, name: "basic"});
        vecs.push_back('{a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, co: 1'b1, name: "ovf_1"});
        vecs.push_back('{a: 8'hFF, b: 8'hFF, sub: 1'b0, sum: 8'hFE, co: 1'b1, name: "ovf_ff"});
        vecs.push_back('{a: 8'h00, b: 8'h00, sub: 1'b0, sum: 8'h00, co: 1'b0, name: "zero"});
        vecs.push_back('{a: 8'h80, b: 8'h80, sub: 1'b0, sum: 8'h00, co: 1'b1, name: "msb_carry"});
        vecs.push_back('{a: 8'hA5, b: 8'h5A, sub: 1'b0, sum: 8'hFF, co: 1'b0, name: "no_carry"});
        vecs.push_back('{a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, co: 1'b0, name: "ripple"});
`ifdef SERIAL_ADDH_SUB_EN
        vecs.push_back('{a: 8'h10, b: 8'h03, sub: 1'b1, sum: 8'h0D, co: 1'b1, name: "sub_pos"});
        vecs.push_back('{a: 8'h03, b: 8'h10, sub: 1'b1, sum: 8'hF3, co: 1'b0, name: "sub_neg"});
        vecs.push_back('{a: 8'h55, b: 8'h55, sub: 1'b1, sum: 8'h00, co: 1'b1, name: "sub_eq"});
`endif
        foreach (vecs[i]) do_op8(vecs[i]);

        // Backpressure: result held, input ignored while DONE.
        ordy8 = 1'b0;
        sb8.push_back('{sum: 8'h46, co: 1'b0});
        start8(8'h12, 8'h34, 1'b0);
        wait_out8(edges);
        chk("bp_latency", edges, 9);
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_valid", ov8, 1);
            chk("bp_sum", s8, 8'h46);
            chk("bp_co", co8, 0);
            chk("bp_in_ready", ir8, 0);
            iv8 = (i % 3 == 0);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            @(negedge clk);
        end
        iv8 = 1'b0;
        pop8("bp");
        ordy8 = 1'b1;
        @(negedge clk);
        chk("bp_release_ov", ov8, 0);
        chk("bp_release_ir", ir8, 1);
        @(negedge clk);
        chk("bp_idle_ir", ir8, 1);
        chk("bp_sum_hold", s8, 8'h46);

        // WIDTH=1: done two edges after accept.
        ordy1 = 1'b1;
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0;
        chk("w1_edge1_ov", ov1, 0);
        @(posedge clk);
        @(negedge clk);
        chk("w1_ov", ov1, 1);
        chk("w1_sum", s1, 0);
        chk("w1_co", co1, 1);
        @(negedge clk);
        chk("w1_post_ir", ir1, 1);

        // WIDTH=13 random regression with gaps on both sides.
        fork
            begin : drv13
                int gap;
                int n;
                logic sub;
                for (int i = 0; i < 1000; i++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) @(negedge clk);
                    a13 = 13'($urandom);
                    b13 = 13'($urandom);
                    sub = 1'b0;
`ifdef SERIAL_ADDH_SUB_EN
                    sub   = 1'($urandom_range(0, 1));
                    sub13 = sub;
`endif
                    iv13 = 1'b1;
                    n = 0;
                    while (!ir13 && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                    chk("w13_in_ready", ir13, 1);
                    if (!ir13) begin
                        iv13 = 1'b0;
                        break;
                    end
                    @(posedge clk);
                    if (sub)
                        sb13.push_back({1'b0, a13} + {1'b0, ~b13} + 14'd1);
                    else
                        sb13.push_back({1'b0, a13} + {1'b0, b13});
                    @(negedge clk);
                    iv13 = 1'b0;
                end
            end
            begin : mon13
                int got;
                int cyc;
                logic [13:0] e;
                got = 0;
                cyc = 0;
                while (got < 1000 && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    ordy13 = ($urandom_range(0, 1) == 1);
                    if (ov13 && ordy13) begin
                        chk("w13_sb_nonempty", (sb13.size() != 0), 1);
                        if (sb13.size() != 0) begin
                            e = sb13.pop_front();
                            chk("w13_result", {co13, s13}, e);
                        end
                        got++;
                    end
                end
                chk("w13_result_count", got, 1000);
            end
        join
        ordy13 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
